rom_access_arbiter: RTL and testbench
=====================================

# rom_access_arbiter

Sequences and shares the single read port of the 8-bit program ROM between two requesters: the CPU instruction-fetch unit (port 0) and the constant/data-load path (port 1). Each access runs through a fixed state machine: arbitrate, drive and hold the address, wait a programmable number of cycles, capture the data, then pulse a per-port valid. The block sits between the CPU core and the ROM. No other module drives the ROM address once this block is instantiated.

## Interface
- ADDR_W, 8, ROM address width
- DATA_W, 8, ROM data width
- WAIT_CYCLES, 0, extra ROM settling cycles after the address is driven, 0..15 (reserved for a future synchronous ROM)

- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req0  input  1  fetch request; level, held until valid0
- addr0  input  ADDR_W  fetch address, sampled only on grant
- req1  input  1  load request; level, held until valid1
- addr1  input  ADDR_W  load address, sampled only on grant
- valid0  output  1  one-cycle pulse: rdata belongs to port 0
- valid1  output  1  one-cycle pulse: rdata belongs to port 1
- rdata  output  DATA_W  registered read data, stable from the valid pulse until the next capture
- busy  output  1  high in every state except IDLE
- rom_addr  output  ADDR_W  registered address to the ROM
- rom_data  input  DATA_W  ROM read data, combinational from rom_addr

## Operation
- States are IDLE, READ and RESP.
- **IDLE**
  - If no request is pending, stay in IDLE.
  - If only one request is pending, grant it.
  - If both are pending, grant the port that did not win last; last_winner resets to 1, so port 0 wins first.
  - On grant: rom_addr <= the winner's address, wait_cnt <= WAIT_CYCLES, cur <= winner, go to READ.
- **READ**
  - rom_addr is held.
  - If wait_cnt != 0, decrement it.
  - If wait_cnt == 0, rdata <= rom_data, go to RESP.
- **RESP**
  - valid[cur] = 1, last_winner <= cur, go to IDLE.
- valid0 and valid1 are decoded from state and cur. They are never high together.
- A requester must sample valid on the rising edge. To issue a new access back-to-back, it keeps req high and changes addr on that same edge. IDLE then re-arbitrates with the updated last_winner, so alternating ports interleave.
- addr changes while an access is in flight are ignored; the address is latched at grant.
- If req drops before valid, the access still completes and valid still pulses. The requester ignores it.
- A single requester gets no fairness penalty: it is granted every time, whatever last_winner holds.
- Reset (asynchronous, any state): state=IDLE, rom_addr=0, rdata=0, cur=0, wait_cnt=0, last_winner=1, valid0=valid1=0, busy=0. An in-flight access is discarded without a valid pulse; the requester must re-issue.

## Timing
- Access latency, from the grant edge to the valid cycle: WAIT_CYCLES+2 cycles.
  - Cycle g: IDLE samples req.
  - Cycles g+1 .. g+1+WAIT_CYCLES: READ.
  - Cycle g+2+WAIT_CYCLES: valid high.
- Throughput is one access per WAIT_CYCLES+3 cycles (includes one IDLE cycle).
- rom_addr changes only on the clock edge leaving IDLE with a grant.
- rom_data is sampled on the final READ edge, so the ROM settle path is at least WAIT_CYCLES+1 full cycles.
- Worst-case wait for a port while the other port requests continuously: 2×(WAIT_CYCLES+3) cycles.

## Structure
- Shared package cpu_mem_pkg:
  - ADDR_W and DATA_W constants, shared with the ROM and the CPU core.
  - rom_arb_state_t enum with IDLE/READ/RESP.
- One combinational sub-module, rom_rr_pick2:
  - Inputs: req0, req1, last_winner.
  - Outputs: grant_any and winner.
- The FSM, counter and registers live in the top module.

## Test plan
The bench ROM model holds mem[a] = a ^ 8'hA5, with WAIT_CYCLES=0 unless stated.
- Reset and idle: hold rst_n low 3 cycles, then release with no req -> all outputs 0, busy=0, state IDLE for 10 cycles.
- Single fetch: req0=1, addr0=8'h10 -> rom_addr=8'h10 on the next edge, valid0 two cycles after the grant edge, rdata=8'hB5, valid1 never high.
- Simultaneous requests: req0 and req1 together (addr0=8'h01, addr1=8'hFE), both held for two accesses -> port 0 served first with rdata=8'hA4, then port 1 with rdata=8'h5B, 3 cycles apart.
- Back-to-back single port: req1 held high with addr1 stepping 8'hFF→8'h00 on each valid -> rdata 8'h5A then 8'hA5, one access every 3 cycles, rom_addr wrapping cleanly.
- Wait states: WAIT_CYCLES=3, req0 with addr0=8'h20 -> valid0 exactly 5 cycles after the grant edge, rdata=8'h85; changing addr0 mid-access has no effect.
- Reset mid-access: assert rst_n low during READ -> outputs 0 immediately with no valid pulse; after release, a re-issued req1 with addr1=8'h33 is granted before port 0 (last_winner=1 after reset).

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: memory-bus widths shared by the CPU core, the ROM and the ROM arbiter.
package cpu_mem_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    typedef enum logic [1:0] {IDLE, READ, RESP} rom_arb_state_t;
endpackage

// File: rtl/rom_rr_pick2.sv
// rom_rr_pick2: two-way round-robin pick; a lone requester always wins, a tie goes to the port that did not win last.
module rom_rr_pick2 (
    input  logic req0,
    input  logic req1,
    input  logic last_winner,
    output logic grant_any,
    output logic winner
);
    assign grant_any = req0 | req1;
    assign winner    = (req0 & req1) ? ~last_winner : req1;
endmodule

// File: rtl/rom_access_arbiter.sv
// rom_access_arbiter: shares the single ROM read port between instruction fetch (port 0) and data load (port 1).
module rom_access_arbiter #(
    parameter int ADDR_W      = cpu_mem_pkg::ADDR_W,
    parameter int DATA_W      = cpu_mem_pkg::DATA_W,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              valid0,
    output logic              valid1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);
    import cpu_mem_pkg::*;

    rom_arb_state_t    state, state_n;
    logic [ADDR_W-1:0] addr_n;
    logic [DATA_W-1:0] rdata_n;
    logic [3:0]        wait_cnt, cnt_n;
    logic              cur, cur_n, last_winner, lw_n, grant_any, winner;

    rom_rr_pick2 u_pick (.req0(req0), .req1(req1), .last_winner(last_winner), .grant_any(grant_any), .winner(winner));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rom_addr    <= '0;
            rdata       <= '0;
            cur         <= 1'b0;
            wait_cnt    <= 4'd0;
            last_winner <= 1'b1;
        end else begin
            state       <= state_n;
            rom_addr    <= addr_n;
            rdata       <= rdata_n;
            cur         <= cur_n;
            wait_cnt    <= cnt_n;
            last_winner <= lw_n;
        end
    end

    // The address is latched only at grant, so requester address changes mid-access are ignored.
    always_comb begin
        state_n = state;
        addr_n  = rom_addr;
        rdata_n = rdata;
        cur_n   = cur;
        cnt_n   = wait_cnt;
        lw_n    = last_winner;
        case (state)
            IDLE: if (grant_any) begin
                state_n = READ;
                addr_n  = winner ? addr1 : addr0;
                cnt_n   = 4'(WAIT_CYCLES);
                cur_n   = winner;
            end
            READ: if (wait_cnt != 4'd0) cnt_n = wait_cnt - 4'd1;
                  else begin
                      rdata_n = rom_data;
                      state_n = RESP;
                  end
            RESP: begin
                lw_n    = cur;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign valid0 = (state == RESP) && !cur;
    assign valid1 = (state == RESP) && cur;
    assign busy   = (state != IDLE);
endmodule

// File: tb/tb_rom_access_arbiter.sv
// tb_rom_access_arbiter: scenario tasks against a transaction-level model (round-robin order, fixed latency, mem[a] = a ^ 8'hA5).
module tb_rom_access_arbiter;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       req0 = 1'b0, req1 = 1'b0;
    logic [7:0] addr0 = '0, addr1 = '0, rdata, rom_addr, rom_data;
    logic       v0, v1, busy;
    logic       wreq0 = 1'b0, wreq1 = 1'b0;
    logic [7:0] waddr0 = '0, waddr1 = '0, wrdata, wrom_addr, wrom_data;
    logic       wv0, wv1, wbusy;

    assign rom_data  = rom_addr ^ 8'hA5;
    assign wrom_data = wrom_addr ^ 8'hA5;

    rom_access_arbiter #(.WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .addr0(addr0), .req1(req1), .addr1(addr1),
        .valid0(v0), .valid1(v1), .rdata(rdata), .busy(busy), .rom_addr(rom_addr), .rom_data(rom_data));

    rom_access_arbiter #(.WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst_n(rst_n), .req0(wreq0), .addr0(waddr0), .req1(wreq1), .addr1(waddr1),
        .valid0(wv0), .valid1(wv1), .rdata(wrdata), .busy(wbusy), .rom_addr(wrom_addr), .rom_data(wrom_data));

    int checks = 0, errors = 0;
    int model_last = 1;
    logic [7:0] aq0 [16];
    logic [7:0] aq1 [16];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next valid on u0 (bounded); returns port (-1 on timeout) and negedges waited.
    task automatic wait_valid(output int port, output int cyc);
        port = -1;
        cyc  = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (v0 || v1) begin
                checks++;
                if (v0 && v1) begin
                    errors++;
                    $display("FAIL dual_valid: valid0=%0b valid1=%0b, required only one high", v0, v1);
                end
                port = v1 ? 1 : 0;
                cyc  = i;
                return;
            end
        end
    endtask

    // Each requester holds req and steps its address on every own valid until its count is spent.
    task automatic run_traffic(string name, int n0, int n1);
        int r0 = n0, r1 = n1, i0 = 0, i1 = 0, exp_port, port, cyc;
        logic [7:0] exp_addr;
        req0 = r0 > 0; req1 = r1 > 0; addr0 = aq0[0]; addr1 = aq1[0];
        while (r0 > 0 || r1 > 0) begin
            exp_port = (r0 > 0 && r1 > 0) ? 1 - model_last : (r0 > 0 ? 0 : 1);
            exp_addr = exp_port == 1 ? aq1[i1] : aq0[i0];
            wait_valid(port, cyc);
            checks++;
            if (port !== exp_port || cyc !== 3 || rdata !== (exp_addr ^ 8'hA5) || rom_addr !== exp_addr) begin
                errors++;
                $display("FAIL %s: port=%0d cyc=%0d rdata=%h rom_addr=%h, required port=%0d cyc=3 rdata=%h rom_addr=%h",
                         name, port, cyc, rdata, rom_addr, exp_port, exp_addr ^ 8'hA5, exp_addr);
                if (port < 0) break;
            end
            model_last = exp_port;
            if (exp_port == 0) begin r0--; i0++; end
            else begin r1--; i1++; end
            step();
            req0 = r0 > 0; req1 = r1 > 0; addr0 = aq0[i0]; addr1 = aq1[i1];
        end
        req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({v0, v1, busy, rdata, rom_addr, wv0, wv1, wbusy, wrdata, wrom_addr} !== 38'd0) begin
            errors++;
            $display("FAIL reset_hold: u0 v=%b%b busy=%b rdata=%h rom_addr=%h u3 v=%b%b busy=%b, required all 0",
                     v0, v1, busy, rdata, rom_addr, wv0, wv1, wbusy);
        end
        step();
        rst_n = 1'b1;
        model_last = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({v0, v1, busy, rdata, rom_addr, wv0, wv1, wbusy, wrdata, wrom_addr} !== 38'd0) begin
                errors++;
                $display("FAIL reset_idle[%0d]: u0 v=%b%b busy=%b rdata=%h rom_addr=%h, required all 0",
                         i, v0, v1, busy, rdata, rom_addr);
            end
        end
    endtask

    task automatic test_simultaneous();
        aq0[0] = 8'h01; aq0[1] = 8'h01; aq1[0] = 8'hFE; aq1[1] = 8'hFE;
        step();
        run_traffic("simultaneous", 2, 2);
    endtask

    task automatic test_single_fetch();
        int port, cyc;
        step();
        req0 = 1'b1; addr0 = 8'h10;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (rom_addr !== 8'h10 || busy !== 1'b1 || v0 !== 1'b0 || v1 !== 1'b0) begin
            errors++;
            $display("FAIL single_grant: rom_addr=%h busy=%b v=%b%b, required rom_addr=10 busy=1 v=00", rom_addr, busy, v0, v1);
        end
        wait_valid(port, cyc);
        checks++;
        if (port !== 0 || cyc !== 1 || rdata !== 8'hB5) begin
            errors++;
            $display("FAIL single_valid: port=%0d cyc=%0d rdata=%h, required port=0 cyc=1 rdata=b5", port, cyc, rdata);
        end
        step();
        req0 = 1'b0;
        model_last = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || v0 !== 1'b0 || v1 !== 1'b0 || rdata !== 8'hB5) begin
            errors++;
            $display("FAIL single_after: busy=%b v=%b%b rdata=%h, required busy=0 v=00 rdata=b5", busy, v0, v1, rdata);
        end
    endtask

    task automatic test_back_to_back();
        aq1[0] = 8'hFF; aq1[1] = 8'h00;
        step();
        run_traffic("back_to_back", 0, 2);
    endtask

    task automatic test_wait_states();
        int seen = -1;
        logic seen1 = 1'b0;
        step();
        wreq0 = 1'b1; waddr0 = 8'h20;
        for (int i = 1; i <= 20 && seen < 0; i++) begin
            @(negedge clk);
            if (i == 2) begin
                checks++;
                if (wrom_addr !== 8'h20 || wbusy !== 1'b1) begin
                    errors++;
                    $display("FAIL wait_grant: rom_addr=%h busy=%b, required rom_addr=20 busy=1", wrom_addr, wbusy);
                end
                waddr0 = 8'h55;
            end
            if (wv1) seen1 = 1'b1;
            if (wv0) seen = i;
        end
        checks++;
        if (seen !== 6 || wrdata !== 8'h85 || wrom_addr !== 8'h20 || seen1) begin
            errors++;
            $display("FAIL wait_states: valid at %0d rdata=%h rom_addr=%h valid1_seen=%b, required 6 85 20 0",
                     seen, wrdata, wrom_addr, seen1);
        end
        step();
        wreq0 = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int port, cyc;
        logic pulse = 1'b0;
        step();
        req0 = 1'b1; addr0 = 8'h44;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b, required 1", busy);
        end
        rst_n = 1'b0;
        req0  = 1'b0;
        #1;
        checks++;
        if ({v0, v1, busy, rdata, rom_addr} !== 19'd0) begin
            errors++;
            $display("FAIL mid_reset: v=%b%b busy=%b rdata=%h rom_addr=%h, required all 0", v0, v1, busy, rdata, rom_addr);
        end
        repeat (3) begin
            @(negedge clk);
            if (v0 || v1 || busy) pulse = 1'b1;
        end
        checks++;
        if (pulse) begin
            errors++;
            $display("FAIL mid_no_pulse: activity during reset=1, required 0");
        end
        step();
        rst_n = 1'b1;
        model_last = 1;
        req1 = 1'b1; addr1 = 8'h33;
        step();
        req0 = 1'b1; addr0 = 8'h44;
        wait_valid(port, cyc);
        checks++;
        if (port !== 1 || cyc !== 2 || rdata !== 8'h96) begin
            errors++;
            $display("FAIL reissue_port1: port=%0d cyc=%0d rdata=%h, required 1 2 96", port, cyc, rdata);
        end
        step();
        req1 = 1'b0;
        wait_valid(port, cyc);
        checks++;
        if (port !== 0 || cyc !== 3 || rdata !== 8'hE1) begin
            errors++;
            $display("FAIL reissue_port0: port=%0d cyc=%0d rdata=%h, required 0 3 e1", port, cyc, rdata);
        end
        step();
        req0 = 1'b0;
        model_last = 0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 16; j++) begin
                aq0[j] = 8'($urandom);
                aq1[j] = 8'($urandom);
            end
            repeat ($urandom_range(0, 3)) step();
            run_traffic("random", $urandom_range(0, 6), $urandom_range(0, 6));
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous();
        test_single_fetch();
        test_back_to_back();
        test_wait_states();
        test_reset_mid_access();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
